// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
//   Byte-level command front end for the ALU. Collects a 6-byte frame
//   (SOF, A lo, A hi, B lo, B hi, FUN) from the UART RX path, loads the
//   operands and function code into the ALU, issues a one-cycle ALU_EN,
//   captures the 16-bit result and returns it to the UART TX path as two
//   bytes, low byte first.
//
// Ports
//   CLK, RST               clock (rising edge), async active-high reset
//   RX_P_DATA, RX_D_VLD    received byte and its one-cycle valid
//   ALU_A, ALU_B, ALU_FUN  registered operands / function code
//   ALU_EN                 one-cycle ALU enable
//   ALU_OUT, ALU_OUT_VLD   ALU result and its one-cycle valid
//   TX_P_DATA, TX_D_VLD    byte to transmit and its one-cycle valid
//   TX_BUSY                UART TX busy
//   CMD_ERR                one-cycle pulse when a frame is aborted
//
// State       | meaning
// ------------+--------------------------------------------------------
// IDLE        | hunting for CMD_SOF, other bytes are ignored
// GET_A_LO    | waiting for operand A bits [7:0]
// GET_A_HI    | waiting for operand A bits [15:8]
// GET_B_LO    | waiting for operand B bits [7:0]
// GET_B_HI    | waiting for operand B bits [15:8]
// GET_FUN     | waiting for the function byte, upper nibble must be 0
// EXEC        | ALU_EN high for this single cycle
// WAIT_RES    | waiting for ALU_OUT_VLD, bounded by the result timer
// TX_LO       | low result byte goes out as soon as TX_BUSY is low
// TX_LO_GRD   | one cycle in which TX_BUSY is not looked at
// TX_HI       | high result byte goes out as soon as TX_BUSY is low
// TX_HI_GRD   | one cycle in which TX_BUSY is not looked at, then IDLE

module alu_cmd_sequencer #(
  parameter logic [7:0] CMD_SOF      = 8'hCC,
  parameter int         BYTE_TIMEOUT = 1023,
  parameter int         ALU_WAIT_MAX = 15
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  RX_P_DATA,
  input  logic        RX_D_VLD,
  output logic [15:0] ALU_A,
  output logic [15:0] ALU_B,
  output logic [3:0]  ALU_FUN,
  output logic        ALU_EN,
  input  logic [15:0] ALU_OUT,
  input  logic        ALU_OUT_VLD,
  output logic [7:0]  TX_P_DATA,
  output logic        TX_D_VLD,
  input  logic        TX_BUSY,
  output logic        CMD_ERR
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    GET_A_LO  = 4'd1,
    GET_A_HI  = 4'd2,
    GET_B_LO  = 4'd3,
    GET_B_HI  = 4'd4,
    GET_FUN   = 4'd5,
    EXEC      = 4'd6,
    WAIT_RES  = 4'd7,
    TX_LO     = 4'd8,
    TX_LO_GRD = 4'd9,
    TX_HI     = 4'd10,
    TX_HI_GRD = 4'd11
  } state_t;

  // Byte timer counts idle cycles in the GET states; the timeout fires in
  // the cycle where BYTE_TIMEOUT idle cycles have already elapsed.
  localparam logic [9:0] BYTE_TC = 10'(BYTE_TIMEOUT);
  // Result timer counts cycles since ALU_EN (EXEC loads 1). The error is
  // raised in cycle ALU_EN+ALU_WAIT_MAX-1, so CMD_ERR is high exactly
  // ALU_WAIT_MAX cycles after ALU_EN.
  localparam logic [3:0] RES_TC  = 4'(ALU_WAIT_MAX - 1);

  state_t      state_q, state_d;
  logic [9:0]  byte_cnt_q, byte_cnt_d;
  logic [3:0]  res_cnt_q, res_cnt_d;
  logic [15:0] a_sh_q, a_sh_d;
  logic [15:0] b_sh_q, b_sh_d;
  logic [15:0] alu_a_q, alu_a_d;
  logic [15:0] alu_b_q, alu_b_d;
  logic [3:0]  alu_fun_q, alu_fun_d;
  logic [15:0] res_q, res_d;
  logic        cmd_err_q, cmd_err_d;

  logic in_get;
  logic byte_to;
  logic res_to;
  logic fun_rx;
  logic fun_bad;
  logic fun_ok;

  assign in_get  = (state_q == GET_A_LO) || (state_q == GET_A_HI) ||
                   (state_q == GET_B_LO) || (state_q == GET_B_HI) ||
                   (state_q == GET_FUN);
  // A byte arriving in the terminal-count cycle wins over the timeout.
  assign byte_to = in_get && !RX_D_VLD && (byte_cnt_q == BYTE_TC);
  assign res_to  = (state_q == WAIT_RES) && !ALU_OUT_VLD && (res_cnt_q == RES_TC);
  assign fun_rx  = (state_q == GET_FUN) && RX_D_VLD;
  assign fun_bad = fun_rx && (RX_P_DATA[7:4] != 4'h0);
  assign fun_ok  = fun_rx && (RX_P_DATA[7:4] == 4'h0);

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (RX_D_VLD && (RX_P_DATA == CMD_SOF)) state_d = GET_A_LO;
      end
      GET_A_LO: begin
        if (RX_D_VLD)     state_d = GET_A_HI;
        else if (byte_to) state_d = IDLE;
      end
      GET_A_HI: begin
        if (RX_D_VLD)     state_d = GET_B_LO;
        else if (byte_to) state_d = IDLE;
      end
      GET_B_LO: begin
        if (RX_D_VLD)     state_d = GET_B_HI;
        else if (byte_to) state_d = IDLE;
      end
      GET_B_HI: begin
        if (RX_D_VLD)     state_d = GET_FUN;
        else if (byte_to) state_d = IDLE;
      end
      GET_FUN: begin
        if (fun_ok)       state_d = EXEC;
        else if (fun_bad) state_d = IDLE;
        else if (byte_to) state_d = IDLE;
      end
      EXEC: begin
        state_d = WAIT_RES;
      end
      WAIT_RES: begin
        if (ALU_OUT_VLD)  state_d = TX_LO;
        else if (res_to)  state_d = IDLE;
      end
      TX_LO: begin
        if (!TX_BUSY)     state_d = TX_LO_GRD;
      end
      TX_LO_GRD: begin
        state_d = TX_HI;
      end
      TX_HI: begin
        if (!TX_BUSY)     state_d = TX_HI_GRD;
      end
      TX_HI_GRD: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Output logic
  // ALU_EN and TX_D_VLD decode the state register directly so that an
  // asynchronous reset removes them immediately.
  // ---------------------------------------------------------------------
  always_comb begin
    ALU_EN    = 1'b0;
    TX_D_VLD  = 1'b0;
    TX_P_DATA = 8'h00;
    unique case (state_q)
      EXEC: begin
        ALU_EN = 1'b1;
      end
      TX_LO: begin
        TX_P_DATA = res_q[7:0];
        TX_D_VLD  = !TX_BUSY;
      end
      TX_HI: begin
        TX_P_DATA = res_q[15:8];
        TX_D_VLD  = !TX_BUSY;
      end
      default: begin
      end
    endcase
  end

  assign ALU_A   = alu_a_q;
  assign ALU_B   = alu_b_q;
  assign ALU_FUN = alu_fun_q;
  assign CMD_ERR = cmd_err_q;

  // ---------------------------------------------------------------------
  // Datapath: shadow registers, ALU load, result capture, timers
  // ---------------------------------------------------------------------
  always_comb begin
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_fun_d = alu_fun_q;
    res_d     = res_q;

    if (RX_D_VLD) begin
      unique case (state_q)
        GET_A_LO: a_sh_d = {a_sh_q[15:8], RX_P_DATA};
        GET_A_HI: a_sh_d = {RX_P_DATA, a_sh_q[7:0]};
        GET_B_LO: b_sh_d = {b_sh_q[15:8], RX_P_DATA};
        GET_B_HI: b_sh_d = {RX_P_DATA, b_sh_q[7:0]};
        default: begin
        end
      endcase
    end

    // Operands and function code move together so the ALU never sees a
    // half-updated command.
    if (fun_ok) begin
      alu_a_d   = a_sh_q;
      alu_b_d   = b_sh_q;
      alu_fun_d = RX_P_DATA[3:0];
    end

    if ((state_q == WAIT_RES) && ALU_OUT_VLD) begin
      res_d = ALU_OUT;
    end

    if (in_get && !RX_D_VLD && !byte_to) begin
      byte_cnt_d = byte_cnt_q + 10'd1;
    end else begin
      byte_cnt_d = 10'd0;
    end

    if (state_q == EXEC) begin
      res_cnt_d = 4'd1;
    end else if ((state_q == WAIT_RES) && !ALU_OUT_VLD && !res_to) begin
      res_cnt_d = res_cnt_q + 4'd1;
    end else begin
      res_cnt_d = 4'd0;
    end

    cmd_err_d = byte_to || res_to || fun_bad;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      a_sh_q     <= 16'h0000;
      b_sh_q     <= 16'h0000;
      alu_a_q    <= 16'h0000;
      alu_b_q    <= 16'h0000;
      alu_fun_q  <= 4'h0;
      res_q      <= 16'h0000;
      byte_cnt_q <= 10'd0;
      res_cnt_q  <= 4'd0;
      cmd_err_q  <= 1'b0;
    end else begin
      a_sh_q     <= a_sh_d;
      b_sh_q     <= b_sh_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_fun_q  <= alu_fun_d;
      res_q      <= res_d;
      byte_cnt_q <= byte_cnt_d;
      res_cnt_q  <= res_cnt_d;
      cmd_err_q  <= cmd_err_d;
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
module tb_alu_cmd_sequencer;

  localparam logic [7:0] SOF          = 8'hCC;
  localparam int         BYTE_TIMEOUT = 1023;
  localparam int         ALU_WAIT_MAX = 15;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  RX_P_DATA;
  logic        RX_D_VLD;
  logic [15:0] ALU_A, ALU_B;
  logic [3:0]  ALU_FUN;
  logic        ALU_EN;
  logic [15:0] ALU_OUT;
  logic        ALU_OUT_VLD;
  logic [7:0]  TX_P_DATA;
  logic        TX_D_VLD;
  logic        TX_BUSY;
  logic        CMD_ERR;

  alu_cmd_sequencer #(
    .CMD_SOF(SOF), .BYTE_TIMEOUT(BYTE_TIMEOUT), .ALU_WAIT_MAX(ALU_WAIT_MAX)
  ) dut (
    .CLK(CLK), .RST(RST),
    .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUN(ALU_FUN), .ALU_EN(ALU_EN),
    .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD),
    .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .TX_BUSY(TX_BUSY),
    .CMD_ERR(CMD_ERR)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge CLK) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // frame_len: bytes of the current frame collected (0 = hunting SOF)
  // tx_idx: -1 nothing to send, 0 low byte, 1 high byte; grd: spacer cycle
  int          m_len, m_idle, m_since, m_tx, m_grd;
  bit          m_en, m_waiting, m_err;
  logic [7:0]  m_bytes [6];
  logic [15:0] m_a, m_b, m_res;
  logic [3:0]  m_fun;

  task automatic model_reset();
    m_len = 0; m_idle = 0; m_since = 0; m_tx = -1; m_grd = 0;
    m_en = 0; m_waiting = 0; m_err = 0;
    m_a = 0; m_b = 0; m_res = 0; m_fun = 0;
  endtask

  task automatic model_step();
    bit err_next;
    err_next = 0;
    if (m_en) begin
      m_en = 0; m_waiting = 1; m_since = 1;
    end else if (m_waiting) begin
      if (ALU_OUT_VLD) begin
        m_res = ALU_OUT; m_waiting = 0; m_tx = 0; m_grd = 0;
      end else if (m_since == ALU_WAIT_MAX - 1) begin
        m_waiting = 0; err_next = 1;
      end else begin
        m_since++;
      end
    end else if (m_tx >= 0) begin
      if (m_grd != 0) begin
        m_grd = 0;
        m_tx = (m_tx == 1) ? -1 : 1;
      end else if (!TX_BUSY) begin
        m_grd = 1;
      end
    end else if (m_len == 0) begin
      if (RX_D_VLD && RX_P_DATA == SOF) begin
        m_len = 1; m_idle = 0;
      end
    end else begin
      if (RX_D_VLD) begin
        m_bytes[m_len] = RX_P_DATA; m_idle = 0;
        if (m_len == 5) begin
          m_len = 0;
          if (RX_P_DATA[7:4] != 0) err_next = 1;
          else begin
            m_a = {m_bytes[2], m_bytes[1]};
            m_b = {m_bytes[4], m_bytes[3]};
            m_fun = RX_P_DATA[3:0];
            m_en = 1;
          end
        end else begin
          m_len++;
        end
      end else if (m_idle == BYTE_TIMEOUT) begin
        m_len = 0; err_next = 1;
      end else begin
        m_idle++;
      end
    end
    m_err = err_next;
  endtask

  always @(posedge CLK or posedge RST) begin
    if (RST) model_reset();
    else     model_step();
  end

  // ---------------- per-cycle compare + event log ----------------
  logic [7:0] tx_log[$];
  int         tx_cyc[$];
  int         en_count = 0, err_count = 0, en_cyc = 0, err_cyc = 0;

  always @(negedge CLK) begin
    bit exp_vld;
    if (!RST) begin
      exp_vld = (m_tx >= 0) && (m_grd == 0) && !TX_BUSY;
      chk("alu_a", ALU_A, m_a);
      chk("alu_b", ALU_B, m_b);
      chk("alu_fun", ALU_FUN, m_fun);
      chk("alu_en", ALU_EN, m_en);
      chk("cmd_err", CMD_ERR, m_err);
      chk("tx_vld", TX_D_VLD, exp_vld);
      if (exp_vld) chk("tx_data", TX_P_DATA, (m_tx == 1) ? m_res[15:8] : m_res[7:0]);
      if (TX_D_VLD) begin tx_log.push_back(TX_P_DATA); tx_cyc.push_back(cyc); end
      if (ALU_EN)   begin en_count++;  en_cyc = cyc;  end
      if (CMD_ERR)  begin err_count++; err_cyc = cyc; end
    end
  end

  // ---------------- ALU responder ----------------
  int          alu_delay = 2;
  bit          alu_silent = 0, alu_rand = 0, spur_en = 0;
  logic [15:0] alu_val = 16'h0;
  int          vld_cyc = 0;
  bit          vld_seen = 0;

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  initial begin
    bit          pend;
    int          cnt;
    logic [15:0] pval;
    pend = 0; cnt = 0; pval = 0;
    ALU_OUT = 16'h0; ALU_OUT_VLD = 1'b0;
    forever begin
      tick();
      ALU_OUT_VLD = 1'b0;
      if (RST) pend = 0;
      else if (pend) begin
        cnt--;
        if (cnt == 0) begin
          ALU_OUT_VLD = 1'b1; ALU_OUT = pval; pend = 0;
          vld_cyc = cyc; vld_seen = 1;
        end
      end else if (ALU_EN === 1'b1 && !alu_silent) begin
        pend = 1;
        cnt  = alu_rand ? int'($urandom_range(1, 16)) : alu_delay;
        pval = alu_rand ? 16'($urandom) : alu_val;
      end else if (spur_en && $urandom_range(0, 19) == 0) begin
        ALU_OUT_VLD = 1'b1; ALU_OUT = 16'($urandom);
      end
    end
  end

  // ---------------- stimulus ----------------
  bit busy_rand = 0;
  int last_byte_cyc = 0;

  task automatic mtick();
    tick();
    if (busy_rand) TX_BUSY = ($urandom_range(0, 2) == 0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    RX_P_DATA = b; RX_D_VLD = 1'b1; last_byte_cyc = cyc;
    mtick();
    RX_D_VLD = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] a, input logic [15:0] b,
                            input logic [7:0] fun, input int gap_max);
    logic [7:0] fr [6];
    fr = '{SOF, a[7:0], a[15:8], b[7:0], b[15:8], fun};
    for (int i = 0; i < 6; i++) begin
      send_byte(fr[i]);
      if (gap_max > 0) repeat ($urandom_range(0, gap_max)) mtick();
    end
  endtask

  task automatic wait_tx(input int n, input int max_cyc, input string name);
    int k;
    k = 0;
    while (tx_log.size() < n && k < max_cyc) begin mtick(); k++; end
    chk(name, 32'(tx_log.size() >= n), 1);
  endtask

  task automatic clear_log();
    tx_log.delete(); tx_cyc.delete();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int e0, r0, k, l0;
    RX_P_DATA = 8'h00; RX_D_VLD = 1'b0; TX_BUSY = 1'b0;
    repeat (3) tick();
    chk("rst_alu_a", ALU_A, 0);   chk("rst_alu_fun", ALU_FUN, 0);
    chk("rst_alu_en", ALU_EN, 0); chk("rst_tx_vld", TX_D_VLD, 0);
    chk("rst_tx_data", TX_P_DATA, 0); chk("rst_cmd_err", CMD_ERR, 0);
    RST = 1'b0;
    repeat (2) mtick();

    // 1: basic frame, result two cycles after ALU_EN
    clear_log(); e0 = en_count; alu_val = 16'h68AC; alu_delay = 2;
    send_frame(16'h1234, 16'h5678, 8'h01, 0);
    wait_tx(2, 100, "t1_tx_done");
    chk("t1_alu_a", ALU_A, 16'h1234); chk("t1_alu_b", ALU_B, 16'h5678);
    chk("t1_alu_fun", ALU_FUN, 4'h1); chk("t1_en_pulses", en_count - e0, 1);
    chk("t1_lo", tx_log[0], 8'hAC);   chk("t1_hi", tx_log[1], 8'h68);
    chk("t1_lo_latency", tx_cyc[0] - en_cyc, 3);
    chk("t1_gap", tx_cyc[1] - tx_cyc[0], 2);
    repeat (5) mtick();

    // 2: noise byte ignored, then frame
    clear_log(); r0 = err_count; alu_val = 16'h0001;
    send_byte(8'h55); mtick();
    send_frame(16'h0005, 16'h0005, 8'h09, 2);
    wait_tx(2, 100, "t2_tx_done");
    chk("t2_alu_fun", ALU_FUN, 4'h9); chk("t2_no_err", err_count - r0, 0);
    chk("t2_lo", tx_log[0], 8'h01);   chk("t2_hi", tx_log[1], 8'h00);
    repeat (5) mtick();

    // 3: bad function code
    e0 = en_count; r0 = err_count;
    send_frame(16'h7777, 16'h8888, 8'h19, 0);
    repeat (5) mtick();
    chk("t3_err", err_count - r0, 1); chk("t3_no_en", en_count - e0, 0);
    chk("t3_fun_kept", ALU_FUN, 4'h9); chk("t3_a_kept", ALU_A, 16'h0005);
    chk("t3_err_cycle", err_cyc - last_byte_cyc, 1);

    // 4: inter-byte timeout, then a normal frame
    r0 = err_count;
    send_byte(SOF); send_byte(8'h11); send_byte(8'h22); l0 = last_byte_cyc;
    repeat (1030) mtick();
    chk("t4_err", err_count - r0, 1);
    chk("t4_err_cycle", err_cyc - l0, 1025);
    clear_log(); alu_val = 16'hBCDE;
    send_frame(16'hABCD, 16'h1111, 8'h02, 1);
    wait_tx(2, 100, "t4_tx_done");
    chk("t4_alu_a", ALU_A, 16'hABCD);
    chk("t4_lo", tx_log[0], 8'hDE); chk("t4_hi", tx_log[1], 8'hBC);
    repeat (5) mtick();

    // 4b: byte arriving in the terminal-count cycle wins
    clear_log(); r0 = err_count; alu_val = 16'h0F0E;
    send_byte(SOF);
    repeat (BYTE_TIMEOUT) mtick();
    send_byte(8'h21); send_byte(8'h43); send_byte(8'h65); send_byte(8'h87);
    send_byte(8'h03);
    wait_tx(2, 100, "t4b_tx_done");
    chk("t4b_no_err", err_count - r0, 0); chk("t4b_alu_a", ALU_A, 16'h4321);
    chk("t4b_lo", tx_log[0], 8'h0E);
    repeat (5) mtick();

    // 5: last accepted result delay, then no result at all
    clear_log(); alu_delay = ALU_WAIT_MAX - 1; alu_val = 16'h5A5A;
    send_frame(16'h0001, 16'h0002, 8'h04, 0);
    wait_tx(2, 100, "t5_late_ok");
    repeat (5) mtick();
    clear_log(); r0 = err_count; alu_silent = 1;
    send_frame(16'h0003, 16'h0004, 8'h05, 0);
    k = 0;
    while (err_count == r0 && k < 60) begin mtick(); k++; end
    chk("t5_err", err_count - r0, 1);
    chk("t5_err_delay", err_cyc - en_cyc, ALU_WAIT_MAX);
    repeat (5) mtick();
    chk("t5_no_tx", tx_log.size(), 0);
    alu_silent = 0; alu_delay = 2;

    // 6: TX_BUSY stall, then reset while the high byte is pending
    clear_log(); e0 = en_count; alu_val = 16'hCAFE; alu_delay = 3; vld_seen = 0;
    send_frame(16'h0102, 16'h0304, 8'h06, 0);
    TX_BUSY = 1'b1;
    k = 0;
    while (!vld_seen && k < 50) begin mtick(); k++; end
    chk("t6_vld_seen", vld_seen, 1);
    repeat (40) mtick();
    chk("t6_held", tx_log.size(), 0);
    TX_BUSY = 1'b0;
    wait_tx(1, 20, "t6_lo_sent");
    TX_BUSY = 1'b1;
    chk("t6_lo", tx_log[0], 8'hFE);
    chk("t6_lo_delayed", 32'((tx_cyc[0] - vld_cyc) >= 40), 1);
    repeat (3) mtick();
    @(negedge CLK); #2;
    RST = 1'b1; #1;
    chk("t6_rst_alu_a", ALU_A, 0);   chk("t6_rst_alu_b", ALU_B, 0);
    chk("t6_rst_fun", ALU_FUN, 0);   chk("t6_rst_en", ALU_EN, 0);
    chk("t6_rst_tx_vld", TX_D_VLD, 0); chk("t6_rst_tx_data", TX_P_DATA, 0);
    chk("t6_rst_err", CMD_ERR, 0);
    tick(); RST = 1'b0; TX_BUSY = 1'b0;
    repeat (20) mtick();
    chk("t6_no_hi", tx_log.size(), 1); chk("t6_en_once", en_count - e0, 1);

    // random traffic against the model
    alu_rand = 1; spur_en = 1; busy_rand = 1;
    for (int i = 0; i < 250; i++) begin
      logic [7:0] fun;
      if ($urandom_range(0, 3) == 0) send_byte(8'($urandom));
      if ($urandom_range(0, 5) == 0) fun = {4'($urandom_range(1, 15)), 4'($urandom)};
      else                           fun = {4'h0, 4'($urandom)};
      send_frame(16'($urandom), 16'($urandom), fun, 2);
      repeat ($urandom_range(0, 50)) mtick();
    end
    busy_rand = 0; spur_en = 0; TX_BUSY = 1'b0;
    repeat (60) mtick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
